// File: rtl/hps_frame_pkg.sv
// rtl/hps_frame_pkg.sv - shared defaults, address widths and read-side state type for hps_frame_server
package hps_frame_pkg;

  localparam int WORDS_DEF   = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int DEPTH_DEF   = 16;
  localparam int WORD_AW_DEF = $clog2(WORDS_DEF);
  localparam int PTR_AW_DEF  = $clog2(DEPTH_DEF);
  localparam int RAM_AW_DEF  = WORD_AW_DEF + PTR_AW_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PRESENT = 2'd2
  } rd_state_t;

endpackage

// File: rtl/hps_frame_server_ram.sv
// rtl/hps_frame_server_ram.sv - simple dual-port frame buffer with registered read (M10K style)
module frame_ram
  import hps_frame_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = RAM_AW_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_data_q;

  // No reset on the array or read register so the block maps onto embedded RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/hps_frame_server.sv
// rtl/hps_frame_server.sv - buffers pulse-record frames and presents one at a time to the HPS PIO inputs
module hps_frame_server
  import hps_frame_pkg::*;
#(
  parameter int WORDS  = WORDS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    hps_read_bit,
  output logic [WORDS*DATA_W-1:0] dcc_data,
  output logic [31:0]             pulse_num_out,
  output logic [31:0]             buff_diff_out,
  output logic                    overrun
);

  localparam int WORD_AW = $clog2(WORDS);
  localparam int PTR_AW  = $clog2(DEPTH);
  localparam int ADDR_W  = PTR_AW + WORD_AW;
  localparam logic [WORD_AW-1:0] WR_LAST = WORD_AW'(WORDS - 1);
  localparam logic [WORD_AW:0]   RD_END  = (WORD_AW+1)'(WORDS);
  localparam logic [PTR_AW:0]    FULL    = (PTR_AW+1)'(DEPTH);

  rd_state_t               state_q, state_d;
  logic [WORD_AW-1:0]      wr_word_q, wr_word_d;
  logic [PTR_AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [WORD_AW:0]        rd_word_q, rd_word_d;
  logic [PTR_AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_AW:0]         count_q, count_d;
  logic [31:0]             pulse_q, pulse_d;
  logic [WORDS*DATA_W-1:0] dcc_q, dcc_d;
  logic                    overrun_q, overrun_d;
  logic                    sync1_q, sync2_q, prev_q;

  logic              in_ready_int;
  logic              wr_en;
  logic              commit;
  logic              ack;
  logic              ack_take;
  logic              rd_en;
  logic [WORD_AW:0]  cap_idx;
  logic [DATA_W-1:0] rd_data;

  assign in_ready_int = (count_q != FULL);
  assign wr_en        = in_valid && in_ready_int;
  assign commit       = wr_en && (wr_word_q == WR_LAST);
  assign ack          = sync2_q ^ prev_q;
  // Acks outside PRESENT are dropped, never queued.
  assign ack_take     = ack && (state_q == PRESENT);
  assign rd_en        = (state_q == LOAD) && (rd_word_q != RD_END);
  assign cap_idx      = rd_word_q - 1'b1;

  frame_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_frame_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({wr_ptr_q, wr_word_q}),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr ({rd_ptr_q, rd_word_q[WORD_AW-1:0]}),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    wr_word_d = wr_word_q;
    wr_ptr_d  = wr_ptr_q;
    rd_word_d = rd_word_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pulse_d   = pulse_q;
    dcc_d     = dcc_q;
    overrun_d = overrun_q | (in_valid & ~in_ready_int);

    if (wr_en) begin
      if (commit) begin
        wr_word_d = '0;
        wr_ptr_d  = wr_ptr_q + 1'b1;
      end else begin
        wr_word_d = wr_word_q + 1'b1;
      end
    end

    if (commit && !ack_take) begin
      count_d = count_q + 1'b1;
    end else if (!commit && ack_take) begin
      count_d = count_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d   = LOAD;
          rd_word_d = '0;
        end
      end
      LOAD: begin
        // Read data lags the issued address by one cycle, so capture word rd_word-1.
        rd_word_d = rd_word_q + 1'b1;
        if (rd_word_q != '0) begin
          dcc_d[32'(cap_idx) * DATA_W +: DATA_W] = rd_data;
        end
        if (rd_word_q == RD_END) begin
          pulse_d   = pulse_q + 32'd1;
          state_d   = PRESENT;
          rd_word_d = '0;
        end
      end
      PRESENT: begin
        if (ack_take) begin
          rd_ptr_d  = rd_ptr_q + 1'b1;
          rd_word_d = '0;
          state_d   = (count_d != '0) ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_word_q <= '0;
      wr_ptr_q  <= '0;
      rd_word_q <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pulse_q   <= '0;
      dcc_q     <= '0;
      overrun_q <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_word_q <= wr_word_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_word_q <= rd_word_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pulse_q   <= pulse_d;
      dcc_q     <= dcc_d;
      overrun_q <= overrun_d;
      sync1_q   <= hps_read_bit;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
    end
  end

  assign in_ready      = in_ready_int;
  assign dcc_data      = dcc_q;
  assign pulse_num_out = pulse_q;
  assign buff_diff_out = 32'(count_q);
  assign overrun       = overrun_q;

endmodule
